// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   - fixed architectural indices (ARM PC alias, MIPS zero register)
//   - default data width and PC read offset
//   - word_t and the ISA mode enum
//   - is_storage_idx(): whether an index maps onto real storage in a mode
package regfile_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_PC_OFFSET = 8;
    localparam int unsigned ARM_PC_IDX    = 15;
    localparam int unsigned MIPS_ZERO_IDX = 0;
    localparam int unsigned ARM_NUM_REGS  = 16;

    typedef logic [DEF_DATA_W-1:0] word_t;

    typedef enum logic {
        ISA_ARM  = 1'b0,
        ISA_MIPS = 1'b1
    } isa_mode_e;

    // ARM: R0..R14 are storage (R15 is the PC alias, R16+ do not exist).
    // MIPS: everything except R0 is storage.
    function automatic logic is_storage_idx(isa_mode_e mode, int unsigned idx);
        if (mode == ISA_MIPS) begin
            return idx != MIPS_ZERO_IDX;
        end
        return idx < ARM_PC_IDX;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: operand-read / writeback bus of the register file.
//   master (decode/writeback side) drives mode, pc, read addresses, the two
//   write ports and busy_set; slave (register file) returns read data, busy
//   flags and the registered R15-write pulse.
interface regfile_mp_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 3
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic                     mode_mips;
    logic [DATA_W-1:0]        pc;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [1:0]               wr_en;
    logic [2*AW-1:0]          wr_addr;
    logic [2*DATA_W-1:0]      wr_data;
    logic                     busy_set;
    logic [AW-1:0]            busy_addr;
    logic                     pc_wr_valid;
    logic [DATA_W-1:0]        pc_wr_data;

    modport master (
        output mode_mips, pc, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        input  rd_data, rd_busy, pc_wr_valid, pc_wr_data
    );

    modport slave (
        input  mode_mips, pc, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        output rd_data, rd_busy, pc_wr_valid, pc_wr_data
    );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port.
//   in : mode, pc, addr, stored_data/stored_busy (raw storage at addr)
//        wr_acc/wr_addr/wr_data (only when REGFILE_BYPASS_EN is defined)
//   out: rd_data, rd_busy
// Macro REGFILE_BYPASS_EN: forward same-cycle accepted writes to the read.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned AW        = 5,
    parameter int unsigned PC_OFFSET = DEF_PC_OFFSET
) (
    input  isa_mode_e           mode,
    input  logic [DATA_W-1:0]   pc,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   stored_data,
    input  logic                stored_busy,
`ifdef REGFILE_BYPASS_EN
    input  logic [1:0]          wr_acc,
    input  logic [2*AW-1:0]     wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
`endif
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_busy
);

    logic [31:0] idx;
    assign idx = 32'(addr);

    always_comb begin
        rd_data = stored_data;
        rd_busy = stored_busy;
`ifdef REGFILE_BYPASS_EN
        // Port 1 is evaluated last so it wins on an address collision.
        // wr_acc already excludes ARM R15 and MIPS R0.
        for (int p = 0; p < 2; p++) begin
            if (wr_acc[p] && (wr_addr[p*AW +: AW] == addr)) begin
                rd_data = wr_data[p*DATA_W +: DATA_W];
                rd_busy = 1'b0;
            end
        end
`endif
        if (mode == ISA_ARM && idx == ARM_PC_IDX) begin
            rd_data = pc + DATA_W'(PC_OFFSET);
            rd_busy = 1'b0;
        end else if (mode == ISA_ARM && idx >= ARM_NUM_REGS) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (mode == ISA_MIPS && idx == MIPS_ZERO_IDX) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NUM_RD read ports, 2 write ports,
// per-register busy scoreboard and ARM/MIPS runtime mode.
//   clk, rst   : clock, asynchronous active-high reset
//   bus (slave): mode/pc/read/write/busy_set inputs, read data, busy flags,
//                registered R15-write pulse (pc_wr_valid/pc_wr_data)
// Macro REGFILE_BYPASS_EN: zero-cycle write-to-read forwarding in the ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_RD    = 3,
    parameter int unsigned PC_OFFSET = DEF_PC_OFFSET
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    isa_mode_e mode;
    assign mode = isa_mode_e'(bus.mode_mips);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                pc_wr_valid_q, pc_wr_valid_d;
    logic [DATA_W-1:0]   pc_wr_data_q, pc_wr_data_d;

    logic [1:0] wr_acc;
    logic [1:0] wr_pc;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr_acc[p] = bus.wr_en[p] && is_storage_idx(mode, 32'(bus.wr_addr[p*AW +: AW]));
            wr_pc[p]  = bus.wr_en[p] && (mode == ISA_ARM)
                        && (32'(bus.wr_addr[p*AW +: AW]) == ARM_PC_IDX);
        end
    end

    always_comb begin
        mem_d         = mem_q;
        busy_d        = busy_q;
        pc_wr_valid_d = |wr_pc;
        pc_wr_data_d  = pc_wr_data_q;
        // Port 1 processed last: wins same-address collisions.
        for (int p = 0; p < 2; p++) begin
            if (wr_acc[p]) begin
                mem_d[bus.wr_addr[p*AW +: AW]]  = bus.wr_data[p*DATA_W +: DATA_W];
                busy_d[bus.wr_addr[p*AW +: AW]] = 1'b0;
            end
            if (wr_pc[p]) begin
                pc_wr_data_d = bus.wr_data[p*DATA_W +: DATA_W];
            end
        end
        // A new producer overrides the clear from a same-cycle write.
        if (bus.busy_set && is_storage_idx(mode, 32'(bus.busy_addr))) begin
            busy_d[bus.busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q         <= '{default: '0};
            busy_q        <= '0;
            pc_wr_valid_q <= 1'b0;
            pc_wr_data_q  <= '0;
        end else begin
            mem_q         <= mem_d;
            busy_q        <= busy_d;
            pc_wr_valid_q <= pc_wr_valid_d;
            pc_wr_data_q  <= pc_wr_data_d;
        end
    end

    assign bus.pc_wr_valid = pc_wr_valid_q;
    assign bus.pc_wr_data  = pc_wr_data_q;

    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = bus.rd_addr[i*AW +: AW];

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .AW       (AW),
            .PC_OFFSET(PC_OFFSET)
        ) u_port (
            .mode       (mode),
            .pc         (bus.pc),
            .addr       (addr),
            .stored_data(mem_q[addr]),
            .stored_busy(busy_q[addr]),
`ifdef REGFILE_BYPASS_EN
            .wr_acc     (wr_acc),
            .wr_addr    (bus.wr_addr),
            .wr_data    (bus.wr_data),
`endif
            .rd_data    (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy    (rd_busy[i])
        );
    end

    assign bus.rd_data = rd_data;
    assign bus.rd_busy = rd_busy;

endmodule
